pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch squash,
// data-memory wait with timeout, and exception flush sequencing.
// Stage enables/flushes are combinational; state and counters are registered.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        exe_is_load,
    input  logic [4:0]  exe_wb_dreg,
    input  logic        exe_bj,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        exc_req,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_exe_en,
    output logic        exe_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_exe_flush,
    output logic        exe_mem_flush,
    output logic        mem_wb_flush,
    output logic        bus_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        EXC      = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        bus_err_q, bus_err_d;
    logic [15:0] stall_q, flush_q;

    logic load_use;
    logic mem_stall;

    // Hazard detection terms
    always_comb begin
        load_use = exe_is_load && (exe_wb_dreg != 5'd0) &&
                   ((id_use_rs && (id_rs == exe_wb_dreg)) ||
                    (id_use_rt && (id_rt == exe_wb_dreg)));
        // Once waiting, only the acknowledge releases the stall.
        if (state_q == MEM_WAIT) begin
            mem_stall = !mem_ack;
        end else begin
            mem_stall = mem_req && !mem_ack;
        end
    end

    // Next-state logic and prioritised stage enable/flush generation
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        bus_err_d     = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_exe_en     = 1'b1;
        exe_mem_en    = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        exe_mem_flush = 1'b0;
        mem_wb_flush  = 1'b0;

        if (rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_en    = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
            mem_wb_flush  = 1'b1;
        end else if (state_q == EXC) begin
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
            mem_wb_flush  = 1'b1;
            state_d       = RUN;
        end else if (exc_req) begin
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
            mem_wb_flush  = 1'b1;
            state_d       = EXC;
        end else if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_en    = 1'b0;
            exe_mem_en   = 1'b0;
            mem_wb_flush = 1'b1;
            if (state_q == RUN) begin
                state_d = MEM_WAIT;
                wait_d  = '0;
            end else if (wait_q == 8'hFF) begin
                state_d   = EXC;
                bus_err_d = 1'b1;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end else begin
            if (state_q == MEM_WAIT) begin
                state_d = RUN;
            end
            if (exe_bj) begin
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
            end else if (load_use) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_exe_flush = 1'b1;
            end
        end
    end

    // State, wait counter, bus error pulse and saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            if (!pc_en && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (if_id_flush && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    // Masking with rst keeps a pending pulse from leaking into a reset cycle.
    always_comb begin
        bus_err   = bus_err_q && !rst;
        stall_cnt = stall_q;
        flush_cnt = flush_q;
        state     = state_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver applies directed
// vectors and queues hand-computed expectations; a negedge monitor checks them.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, exe_wb_dreg;
    logic        id_use_rs, id_use_rt, exe_is_load, exe_bj;
    logic        mem_req, mem_ack, exc_req;
    logic        pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
    logic        if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush;
    logic        bus_err;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  state;

    typedef struct packed {
        logic [4:0]  en;
        logic [3:0]  fl;
        logic [1:0]  st;
        logic        be;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    logic [15:0] m_stall = '0;
    logic [15:0] m_flush = '0;

    localparam logic [4:0] EN_ALL   = 5'b11111;
    localparam logic [4:0] EN_NONE  = 5'b00000;
    localparam logic [4:0] EN_LU    = 5'b00111;
    localparam logic [4:0] EN_STALL = 5'b00001;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .exe_is_load(exe_is_load), .exe_wb_dreg(exe_wb_dreg), .exe_bj(exe_bj),
        .mem_req(mem_req), .mem_ack(mem_ack), .exc_req(exc_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
        .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
        .exe_mem_flush(exe_mem_flush), .mem_wb_flush(mem_wb_flush),
        .bus_err(bus_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic ld,
                         input logic [4:0] dreg, input logic bj, input logic mrq,
                         input logic mak, input logic ex);
        rst = r; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        exe_is_load = ld; exe_wb_dreg = dreg; exe_bj = bj;
        mem_req = mrq; mem_ack = mak; exc_req = ex;
    endtask

    task automatic idle(input logic r);
        apply(r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue the expectation for the current cycle, advance the counter model, step a clock
    task automatic expect_cyc(input string nm, input logic [4:0] en, input logic [3:0] fl,
                              input logic [1:0] st, input logic be);
        exp_t e;
        e.en = en; e.fl = fl; e.st = st; e.be = be; e.sc = m_stall; e.fc = m_flush;
        sb_q.push_back(e);
        name_q.push_back(nm);
        if (rst) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (!en[4] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (fl[3] && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the live outputs mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = sb_q.pop_front();
            nm = name_q.pop_front();
            a.en = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en};
            a.fl = {if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush};
            a.st = state; a.be = bus_err; a.sc = stall_cnt; a.fc = flush_cnt;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got en=%b fl=%b st=%0d be=%b sc=%0d fc=%0d, want en=%b fl=%b st=%0d be=%b sc=%0d fc=%0d",
                         nm, a.en, a.fl, a.st, a.be, a.sc, a.fc,
                         e.en, e.fl, e.st, e.be, e.sc, e.fc);
            end
        end
    end

    initial begin
        idle(1'b1);
        @(posedge clk); #1;
        expect_cyc("reset", EN_NONE, 4'b1111, 2'd0, 1'b0);

        idle(1'b0);
        expect_cyc("default", EN_ALL, 4'b0000, 2'd0, 1'b0);

        // Load-use through rs, then through rt, plus non-hazard variants
        apply(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cyc("loaduse_rs", EN_LU, 4'b0100, 2'd0, 1'b0);
        idle(1'b0);
        expect_cyc("after_loaduse", EN_ALL, 4'b0000, 2'd0, 1'b0);
        apply(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cyc("loaduse_r0", EN_ALL, 4'b0000, 2'd0, 1'b0);
        apply(1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cyc("loaduse_rt", EN_LU, 4'b0100, 2'd0, 1'b0);
        apply(1'b0, 5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cyc("rt_unused", EN_ALL, 4'b0000, 2'd0, 1'b0);
        apply(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cyc("not_load", EN_ALL, 4'b0000, 2'd0, 1'b0);

        // Taken branch alone and over a load-use
        apply(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cyc("bj_over_loaduse", EN_ALL, 4'b1100, 2'd0, 1'b0);
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cyc("bj_alone", EN_ALL, 4'b1100, 2'd0, 1'b0);
        idle(1'b0);
        expect_cyc("after_bj", EN_ALL, 4'b0000, 2'd0, 1'b0);

        // Three stalled cycles, branch+load-use suppressed mid-wait, then ack
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_cyc("mem_stall1", EN_STALL, 4'b0001, 2'd0, 1'b0);
        apply(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_cyc("mem_stall2_bj", EN_STALL, 4'b0001, 2'd1, 1'b0);
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_cyc("mem_stall3", EN_STALL, 4'b0001, 2'd1, 1'b0);
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_cyc("mem_ack", EN_ALL, 4'b0000, 2'd1, 1'b0);
        idle(1'b0);
        expect_cyc("mem_done", EN_ALL, 4'b0000, 2'd0, 1'b0);

        // Exception during wait, coincident with ack: exception wins
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_cyc("exc_wait_a", EN_STALL, 4'b0001, 2'd0, 1'b0);
        expect_cyc("exc_wait_b", EN_STALL, 4'b0001, 2'd1, 1'b0);
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_cyc("exc_req_wait", EN_ALL, 4'b1111, 2'd1, 1'b0);
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_cyc("exc_state", EN_ALL, 4'b1111, 2'd2, 1'b0);
        idle(1'b0);
        expect_cyc("exc_to_run", EN_ALL, 4'b0000, 2'd0, 1'b0);

        // Exception raised from RUN
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_cyc("exc_req_run", EN_ALL, 4'b1111, 2'd0, 1'b0);
        idle(1'b0);
        expect_cyc("exc_state_run", EN_ALL, 4'b1111, 2'd2, 1'b0);
        expect_cyc("exc_run_back", EN_ALL, 4'b0000, 2'd0, 1'b0);

        // Memory timeout: 256 waiting cycles, then one EXC cycle with bus_err
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_cyc("to_enter", EN_STALL, 4'b0001, 2'd0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            expect_cyc("to_wait", EN_STALL, 4'b0001, 2'd1, 1'b0);
        end
        idle(1'b0);
        expect_cyc("to_bus_err", EN_ALL, 4'b1111, 2'd2, 1'b1);
        expect_cyc("to_after", EN_ALL, 4'b0000, 2'd0, 1'b0);

        // Reset aborts MEM_WAIT
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_cyc("rstw_a", EN_STALL, 4'b0001, 2'd0, 1'b0);
        expect_cyc("rstw_b", EN_STALL, 4'b0001, 2'd1, 1'b0);
        apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_cyc("rstw_rst", EN_NONE, 4'b1111, 2'd1, 1'b0);
        idle(1'b0);
        expect_cyc("rstw_after", EN_ALL, 4'b0000, 2'd0, 1'b0);

        // Reset aborts EXC
        apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_cyc("rste_req", EN_ALL, 4'b1111, 2'd0, 1'b0);
        idle(1'b1);
        expect_cyc("rste_rst", EN_NONE, 4'b1111, 2'd2, 1'b0);
        idle(1'b0);
        expect_cyc("rste_after", EN_ALL, 4'b0000, 2'd0, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
